// File: rtl/debounce_multi.sv
// N-channel symmetric switch debouncer with 2-FF synchronizers,
// sample-tick prescale and registered level / rise / fall outputs.
module debounce_multi #(
   parameter int CHANNELS       = 4,
   parameter int DEBOUNCE_LIMIT = 40,
   parameter int CNT_WIDTH      = 20,
   parameter bit INIT_LEVEL     = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sample_en,
   input  logic [CHANNELS-1:0] switch_in,
   output logic [CHANNELS-1:0] switch_out,
   output logic [CHANNELS-1:0] rise_pulse,
   output logic [CHANNELS-1:0] fall_pulse
);

   localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(DEBOUNCE_LIMIT);
   localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);
   localparam logic [CHANNELS-1:0]  INIT  = {CHANNELS{INIT_LEVEL}};

   logic [CHANNELS-1:0]  sync1;
   logic [CHANNELS-1:0]  sync2;
   logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
   logic [CNT_WIDTH-1:0] cnt_d [CHANNELS];
   logic [CHANNELS-1:0]  lvl_d;
   logic [CHANNELS-1:0]  rise_d;
   logic [CHANNELS-1:0]  fall_d;

   // Two-stage synchronizer; only sync2 is ever looked at downstream.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= INIT;
         sync2 <= INIT;
      end else begin
         sync1 <= switch_in;
         sync2 <= sync1;
      end
   end

   // Per-channel qualification: a match clears the run, enabled
   // mismatches count up, and the sample after reaching the limit flips.
   always_comb begin
      lvl_d  = switch_out;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2[i] == switch_out[i]) begin
            cnt_d[i] = '0;
         end else if (sample_en) begin
            if (cnt_q[i] == LIMIT) begin
               lvl_d[i]  = sync2[i];
               rise_d[i] = sync2[i];
               fall_d[i] = ~sync2[i];
               cnt_d[i]  = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + ONE;
            end
         end
      end
   end

   // Registered level, pulses and run counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         switch_out <= INIT;
         rise_pulse <= '0;
         fall_pulse <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         switch_out <= lvl_d;
         rise_pulse <= rise_d;
         fall_pulse <= fall_d;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: vector table, corner-case sequences
// and a randomized run against a run-length reference model.
module tb_debounce_multi;

   localparam int C = 4;
   localparam int L = 4;
   localparam int W = 8;
   localparam bit INIT = 1'b0;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         sample_en;
   logic [C-1:0] switch_in;
   logic [C-1:0] switch_out;
   logic [C-1:0] rise_pulse;
   logic [C-1:0] fall_pulse;

   int total = 0;
   int bad   = 0;

   debounce_multi #(
      .CHANNELS(C),
      .DEBOUNCE_LIMIT(L),
      .CNT_WIDTH(W),
      .INIT_LEVEL(INIT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sample_en(sample_en),
      .switch_in(switch_in),
      .switch_out(switch_out),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse)
   );

   always #5 clk = ~clk;

   // reference model: input history and run length of enabled mismatches
   logic [C-1:0] m_hist [2];
   logic [C-1:0] m_lvl;
   logic [C-1:0] m_rise;
   logic [C-1:0] m_fall;
   int           m_run [C];

   task automatic model_edge(input bit r, input bit e, input logic [C-1:0] d);
      logic [C-1:0] seen;
      if (!r) begin
         m_hist[0] = {C{INIT}};
         m_hist[1] = {C{INIT}};
         m_lvl = {C{INIT}};
         m_rise = '0;
         m_fall = '0;
         for (int c = 0; c < C; c++) m_run[c] = 0;
      end else begin
         seen = m_hist[1];
         m_rise = '0;
         m_fall = '0;
         for (int c = 0; c < C; c++) begin
            if (seen[c] == m_lvl[c]) begin
               m_run[c] = 0;
            end else if (e) begin
               m_run[c] = m_run[c] + 1;
               if (m_run[c] == L + 1) begin
                  m_lvl[c] = seen[c];
                  m_rise[c] = seen[c];
                  m_fall[c] = !seen[c];
                  m_run[c] = 0;
               end
            end
         end
         m_hist[1] = m_hist[0];
         m_hist[0] = d;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit r, input bit e, input logic [C-1:0] d);
      rst_n = r;
      sample_en = e;
      switch_in = d;
      @(posedge clk);
      model_edge(r, e, d);
      #1;
      chk("model", {20'd0, switch_out, rise_pulse, fall_pulse},
          {20'd0, m_lvl, m_rise, m_fall});
      chk("excl", {28'd0, rise_pulse & fall_pulse}, 32'd0);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b1, '0);
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, '0);
   endtask

   task automatic glitch(input int n, output int nr, output int nf,
                         output int redge);
      nr = 0;
      nf = 0;
      redge = -1;
      for (int k = 1; k <= n + 12; k++) begin
         step(1'b1, 1'b1, (k <= n) ? 4'b0010 : 4'b0000);
         if (rise_pulse[1]) begin
            nr++;
            redge = k;
         end
         if (fall_pulse[1]) nf++;
      end
   endtask

   typedef struct {
      bit           rst_n;
      bit           en;
      logic [C-1:0] in;
      logic [C-1:0] out;
      logic [C-1:0] rise;
      logic [C-1:0] fall;
   } vec_t;

   vec_t tv[$];

   task automatic add(input int n, input bit r, input logic [C-1:0] d,
                      input logic [C-1:0] o, input logic [C-1:0] rs,
                      input logic [C-1:0] fl);
      vec_t v;
      v.rst_n = r;
      v.en = 1'b1;
      v.in = d;
      v.out = o;
      v.rise = rs;
      v.fall = fl;
      for (int k = 0; k < n; k++) tv.push_back(v);
   endtask

   initial begin
      int nr;
      int nf;
      int redge;
      int cnt;
      logic [C-1:0] rv;
      logic [C-1:0] d;

      rst_n = 1'b0;
      sample_en = 1'b1;
      switch_in = '0;

      // reset with inputs high, idle, press ch0, release ch0
      add(3, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
      add(3, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
      add(6, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0);
      add(1, 1'b1, 4'h1, 4'h1, 4'h1, 4'h0);
      add(1, 1'b1, 4'h1, 4'h1, 4'h0, 4'h0);
      add(6, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0);
      add(1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h1);
      add(1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);

      for (int i = 0; i < tv.size(); i++) begin
         step(tv[i].rst_n, tv[i].en, tv[i].in);
         chk($sformatf("vec%0d", i),
             {20'd0, switch_out, rise_pulse, fall_pulse},
             {20'd0, tv[i].out, tv[i].rise, tv[i].fall});
      end

      // glitch of L samples is rejected
      do_reset();
      glitch(L, nr, nf, redge);
      chk("glitch_short_rise", nr, 0);
      chk("glitch_short_fall", nf, 0);
      chk("glitch_short_lvl", {31'd0, switch_out[1]}, 32'd0);

      // L+1 samples qualifies, on the L+3rd edge
      do_reset();
      glitch(L + 1, nr, nf, redge);
      chk("glitch_long_rise", nr, 1);
      chk("glitch_long_edge", redge, L + 3);
      chk("glitch_long_fall", nf, 1);

      // prescale: one enabled sample in three
      do_reset();
      cnt = 0;
      redge = -1;
      for (int k = 1; k <= 30; k++) begin
         step(1'b1, (k % 3) == 0, 4'b0100);
         if (rise_pulse[2]) begin
            cnt++;
            redge = k;
         end
      end
      chk("prescale_cnt", cnt, 1);
      chk("prescale_edge", redge, 15);
      chk("prescale_lvl", {28'd0, switch_out}, 32'h4);

      // reset mid-count, then all channels qualify together
      do_reset();
      for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 4'hF);
      chk("midcnt_lvl", {28'd0, switch_out}, 32'h0);
      step(1'b0, 1'b1, 4'hF);
      chk("midrst_out", {20'd0, switch_out, rise_pulse, fall_pulse}, 32'h0);
      redge = -1;
      rv = '0;
      cnt = 0;
      for (int k = 1; k <= 9; k++) begin
         step(1'b1, 1'b1, 4'hF);
         if (rise_pulse != 0) begin
            cnt++;
            if (redge < 0) begin
               redge = k;
               rv = rise_pulse;
            end
         end
      end
      chk("multi_edge", redge, 7);
      chk("multi_rise", {28'd0, rv}, 32'hF);
      chk("multi_cnt", cnt, 1);
      chk("multi_lvl", {28'd0, switch_out}, 32'hF);

      // randomized run against the model
      do_reset();
      d = '0;
      for (int k = 0; k < 1500; k++) begin
         for (int c = 0; c < C; c++) begin
            if ($urandom_range(0, 7) == 0) d[c] = ~d[c];
         end
         step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
